lvds_rx_stream_ctrl: RTL and testbench

Controller between the two LVDS deframers (sub-GHz "09" and 2.4 GHz "24" receivers) and the single shared RX sample FIFO write port. It selects one receiver and qualifies its framed 32-bit I/Q words: I sync in bits [31:30]=2'b10, Q sync in bits [15:14]=2'b01. It acquires lock, streams words into the FIFO, and detects loss of lock (bad framing or missing words). It also counts words dropped on FIFO full and reports status to the host register block.

---
 rtl/lvds_rx_pkg.sv | 27 ++
 rtl/lvds_rx_stream_ctrl_if.sv | 32 +++
 rtl/lvds_rx_gap_timer.sv | 28 ++
 rtl/lvds_rx_stream_ctrl.sv | 153 +++++++++++++++
 tb/tb_lvds_rx_stream_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lvds_rx_pkg.sv
// rtl/lvds_rx_pkg.sv - shared LVDS RX framing constants, state encodings and helpers
package lvds_rx_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ARM    = 2'b01;
  localparam logic [1:0] STREAM = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = IDLE,
    S_ARM    = ARM,
    S_STREAM = STREAM
  } rx_state_e;

  localparam logic [1:0] I_SYNC = 2'b10;
  localparam logic [1:0] Q_SYNC = 2'b01;

  localparam int I_SYNC_HI = 31;
  localparam int I_SYNC_LO = 30;
  localparam int Q_SYNC_HI = 15;
  localparam int Q_SYNC_LO = 14;

  function automatic logic is_framed(input logic [31:0] word);
    return (word[I_SYNC_HI:I_SYNC_LO] == I_SYNC) &&
           (word[Q_SYNC_HI:Q_SYNC_LO] == Q_SYNC);
  endfunction

endpackage

// File: rtl/lvds_rx_stream_ctrl_if.sv
// rtl/lvds_rx_stream_ctrl_if.sv - deframer word strobes and RX sample FIFO write port
interface lvds_rx_stream_ctrl_if;

  logic        valid_09;
  logic [31:0] data_09;
  logic        valid_24;
  logic [31:0] data_24;
  logic        fifo_full;
  logic        fifo_push;
  logic [31:0] fifo_data;

  modport master (
    input  valid_09,
    input  data_09,
    input  valid_24,
    input  data_24,
    input  fifo_full,
    output fifo_push,
    output fifo_data
  );

  modport slave (
    output valid_09,
    output data_09,
    output valid_24,
    output data_24,
    output fifo_full,
    input  fifo_push,
    input  fifo_data
  );

endinterface

// File: rtl/lvds_rx_gap_timer.sv
// rtl/lvds_rx_gap_timer.sv - saturating watchdog counting cycles without a selected word
module lvds_rx_gap_timer #(
  parameter int GAP_MAX = 40
) (
  input  logic i_ddr_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(GAP_MAX + 1);
  localparam logic [W-1:0] LIMIT = W'(GAP_MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge i_ddr_clk) begin
    if (i_reset || clear) begin
      cnt <= '0;
    end else if (run && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the cycle whose increment reaches GAP_MAX, so the caller acts on that same edge.
  assign expired = run && (cnt >= (LIMIT - 1'b1));

endmodule

// File: rtl/lvds_rx_stream_ctrl.sv
// rtl/lvds_rx_stream_ctrl.sv - selects one LVDS deframer, acquires lock and streams words to the RX FIFO
module lvds_rx_stream_ctrl
  import lvds_rx_pkg::*;
#(
  parameter int LOCK_WORDS = 4,
  parameter int GAP_MAX    = 40,
  parameter int CNT_W      = 16
) (
  input  logic                  i_ddr_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_chan_sel,
  input  logic                  i_clear,
  lvds_rx_stream_ctrl_if.master rx,
  output logic                  o_locked,
  output logic                  o_lock_lost,
  output logic [CNT_W-1:0]      o_drop_cnt,
  output logic [1:0]            o_state
);

  rx_state_e   state, state_n;
  logic        r_chan, chan_n;
  logic [3:0]  good, good_n;
  logic        push_q, push_n;
  logic [31:0] data_q;
  logic        lost_set;
  logic        drop_inc;
  logic        gap_clr;
  logic        gap_run;
  logic        gap_exp;

  logic        sel_valid;
  logic [31:0] sel_data;
  logic        framed;

  assign sel_valid = r_chan ? rx.valid_24 : rx.valid_09;
  assign sel_data  = r_chan ? rx.data_24  : rx.data_09;
  assign framed    = is_framed(sel_data);

  lvds_rx_gap_timer #(
    .GAP_MAX (GAP_MAX)
  ) u_gap_timer (
    .i_ddr_clk (i_ddr_clk),
    .i_reset   (i_reset),
    .clear     (gap_clr),
    .run       (gap_run),
    .expired   (gap_exp)
  );

  always_comb begin
    state_n  = state;
    chan_n   = r_chan;
    good_n   = good;
    push_n   = 1'b0;
    lost_set = 1'b0;
    drop_inc = 1'b0;
    gap_clr  = sel_valid;
    gap_run  = (state != S_IDLE) && !sel_valid;

    if (!i_enable) begin
      state_n = S_IDLE;
      good_n  = '0;
      gap_clr = 1'b1;
    end else if (state == S_IDLE) begin
      state_n = S_ARM;
      chan_n  = i_chan_sel;
      good_n  = '0;
      gap_clr = 1'b1;
    end else if (i_chan_sel != r_chan) begin
      // Host retune: restart acquisition on the new receiver, not a lock failure.
      state_n = S_ARM;
      chan_n  = i_chan_sel;
      good_n  = '0;
      gap_clr = 1'b1;
    end else if (state == S_ARM) begin
      if (sel_valid) begin
        if (!framed) begin
          good_n = '0;
        end else if (good == 4'(LOCK_WORDS - 1)) begin
          state_n = S_STREAM;
          good_n  = '0;
        end else begin
          good_n = good + 4'd1;
        end
      end else if (gap_exp) begin
        good_n  = '0;
        gap_clr = 1'b1;
      end
    end else begin
      if (sel_valid && framed) begin
        if (rx.fifo_full) begin
          drop_inc = 1'b1;
        end else begin
          push_n = 1'b1;
        end
      end else if (sel_valid || gap_exp) begin
        state_n  = S_ARM;
        lost_set = 1'b1;
        good_n   = '0;
        gap_clr  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      r_chan   <= 1'b0;
      good     <= '0;
      push_q   <= 1'b0;
      data_q   <= '0;
      o_locked <= 1'b0;
    end else begin
      state    <= state_n;
      r_chan   <= chan_n;
      good     <= good_n;
      push_q   <= push_n;
      o_locked <= (state_n == S_STREAM);
      if (push_n) begin
        data_q <= sel_data;
      end
    end
  end

  // A same-cycle event beats i_clear, so the host never loses the newest drop or loss.
  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      o_lock_lost <= 1'b0;
      o_drop_cnt  <= '0;
    end else begin
      if (lost_set) begin
        o_lock_lost <= 1'b1;
      end else if (i_clear) begin
        o_lock_lost <= 1'b0;
      end

      if (drop_inc) begin
        if (i_clear) begin
          o_drop_cnt <= CNT_W'(1);
        end else if (o_drop_cnt != {CNT_W{1'b1}}) begin
          o_drop_cnt <= o_drop_cnt + 1'b1;
        end
      end else if (i_clear) begin
        o_drop_cnt <= '0;
      end
    end
  end

  assign rx.fifo_push = push_q;
  assign rx.fifo_data = data_q;
  assign o_state      = state;

endmodule

// File: tb/tb_lvds_rx_stream_ctrl.sv
// tb/tb_lvds_rx_stream_ctrl.sv - directed bench with a cycle model and per-cycle output compare
module tb_lvds_rx_stream_ctrl;

  localparam int LOCK_WORDS = 4;
  localparam int GAP_MAX    = 40;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             sel = 1'b0;
  logic             clr = 1'b0;
  logic             locked;
  logic             lost;
  logic [CNT_W-1:0] drop;
  logic [1:0]       st;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  lvds_rx_stream_ctrl_if rx_if ();

  lvds_rx_stream_ctrl #(
    .LOCK_WORDS (LOCK_WORDS),
    .GAP_MAX    (GAP_MAX),
    .CNT_W      (CNT_W)
  ) dut (
    .i_ddr_clk   (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .i_chan_sel  (sel),
    .i_clear     (clr),
    .rx          (rx_if),
    .o_locked    (locked),
    .o_lock_lost (lost),
    .o_drop_cnt  (drop),
    .o_state     (st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: plain integers following the stated rules; 0/1/3 are IDLE/ARM/STREAM.
  int          m_state = 0;
  int          m_good  = 0;
  int          m_idle  = 0;
  int          m_drop  = 0;
  bit          m_chan  = 0;
  bit          m_push  = 0;
  bit          m_lost  = 0;
  logic [31:0] m_data  = '0;

  always @(posedge clk) begin
    bit          v, ok, lost_evt, drop_evt;
    logic [31:0] d;
    if (rst) begin
      m_state = 0; m_good = 0; m_idle = 0; m_drop = 0;
      m_chan  = 0; m_push = 0; m_lost = 0; m_data = '0;
    end else begin
      v  = m_chan ? rx_if.valid_24 : rx_if.valid_09;
      d  = m_chan ? rx_if.data_24  : rx_if.data_09;
      ok = (d[31:30] == 2'b10) && (d[15:14] == 2'b01);
      lost_evt = 0; drop_evt = 0; m_push = 0;
      if (!en) begin
        m_state = 0;
      end else if (m_state == 0 || sel != m_chan) begin
        m_state = 1; m_chan = sel; m_good = 0; m_idle = 0;
      end else begin
        m_idle = v ? 0 : m_idle + 1;
        if (m_state == 1) begin
          if (v && ok) begin
            m_good++;
            if (m_good == LOCK_WORDS) begin m_state = 3; m_good = 0; end
          end else if (v) begin
            m_good = 0;
          end else if (m_idle == GAP_MAX) begin
            m_good = 0; m_idle = 0;
          end
        end else begin
          if (v && ok) begin
            if (rx_if.fifo_full) drop_evt = 1;
            else begin m_push = 1; m_data = d; end
          end else if (v || m_idle == GAP_MAX) begin
            m_state = 1; lost_evt = 1; m_good = 0; m_idle = 0;
          end
        end
      end
      if (lost_evt) m_lost = 1;
      else if (clr) m_lost = 0;
      if (drop_evt) m_drop = clr ? 1 : ((m_drop < (1 << CNT_W) - 1) ? m_drop + 1 : m_drop);
      else if (clr) m_drop = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("state",  32'(st),     32'(m_state));
      chk("locked", 32'(locked), 32'(m_state == 3));
      chk("lost",   32'(lost),   32'(m_lost));
      chk("drop",   32'(drop),   32'(m_drop));
      chk("push",   32'(rx_if.fifo_push), 32'(m_push));
      if (m_push) chk("data", rx_if.fifo_data, m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Drives one word on the chosen channel with framed noise on the other one.
  task automatic word(input bit ch, input logic [31:0] w);
    if (ch) begin
      rx_if.valid_24 = 1'b1; rx_if.data_24 = w;
      rx_if.valid_09 = 1'b1; rx_if.data_09 = 32'h8000_4ABC;
    end else begin
      rx_if.valid_09 = 1'b1; rx_if.data_09 = w;
      rx_if.valid_24 = 1'b1; rx_if.data_24 = 32'h8000_4DEF;
    end
    tick();
    rx_if.valid_09 = 1'b0;
    rx_if.valid_24 = 1'b0;
  endtask

  task automatic lock_on(input bit ch, input logic [31:0] base);
    for (int n = 0; n < LOCK_WORDS; n++) begin
      word(ch, base + 32'(n));
      idle(15);
    end
  endtask

  initial begin
    rx_if.valid_09 = 1'b0; rx_if.data_09 = '0;
    rx_if.valid_24 = 1'b0; rx_if.data_24 = '0;
    rx_if.fifo_full = 1'b0;
    idle(3);
    rst = 1'b0;
    chk_on = 1'b1;

    @(negedge clk);
    chk("rst_state",  32'(st), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_lost",   32'(lost), 32'h0);
    chk("rst_drop",   32'(drop), 32'h0);
    chk("rst_push",   32'(rx_if.fifo_push), 32'h0);

    en = 1'b1; sel = 1'b0;
    tick();
    idle(2);
    for (int n = 0; n < 4; n++) begin
      word(1'b0, 32'h8000_4000 + 32'(n));
      if (n < 3) idle(15);
    end
    @(negedge clk);
    chk("lock_state",  32'(st), 32'h3);
    chk("lock_locked", 32'(locked), 32'h1);
    idle(15);
    for (int n = 4; n < 8; n++) begin
      word(1'b0, 32'h8000_4000 + 32'(n));
      @(negedge clk);
      chk("s1_push", 32'(rx_if.fifo_push), 32'h1);
      chk("s1_data", rx_if.fifo_data, 32'h8000_4000 + 32'(n));
      idle(15);
    end

    word(1'b0, 32'h0000_4000);
    @(negedge clk);
    chk("bad_push",  32'(rx_if.fifo_push), 32'h0);
    chk("bad_state", 32'(st), 32'h1);
    chk("bad_lost",  32'(lost), 32'h1);
    idle(15);
    lock_on(1'b0, 32'h8000_4010);
    @(negedge clk);
    chk("relock_state", 32'(st), 32'h3);
    chk("relock_lost",  32'(lost), 32'h1);
    clr = 1'b1; tick(); clr = 1'b0;
    @(negedge clk);
    chk("clr_lost", 32'(lost), 32'h0);
    idle(10);

    word(1'b0, 32'h8000_4020);
    @(negedge clk);
    chk("gap_push", 32'(rx_if.fifo_push), 32'h1);
    idle(39);
    @(negedge clk);
    chk("gap39_state", 32'(st), 32'h3);
    tick();
    @(negedge clk);
    chk("gap40_state", 32'(st), 32'h1);
    chk("gap40_lost",  32'(lost), 32'h1);
    idle(5);
    lock_on(1'b0, 32'h8000_4030);

    rx_if.fifo_full = 1'b1;
    for (int n = 0; n < 3; n++) begin
      word(1'b0, 32'h8000_4040 + 32'(n));
      @(negedge clk);
      chk("full_push", 32'(rx_if.fifo_push), 32'h0);
      idle(15);
    end
    chk("drop3", 32'(drop), 32'h3);
    clr = 1'b1;
    word(1'b0, 32'h8000_4043);
    clr = 1'b0;
    @(negedge clk);
    chk("drop_clr", 32'(drop), 32'h1);
    chk("lost_clr", 32'(lost), 32'h0);
    rx_if.fifo_full = 1'b0;
    idle(15);

    sel = 1'b1;
    word(1'b0, 32'h8000_4050);
    @(negedge clk);
    chk("sw_push",  32'(rx_if.fifo_push), 32'h0);
    chk("sw_state", 32'(st), 32'h1);
    chk("sw_lost",  32'(lost), 32'h0);
    idle(15);
    lock_on(1'b1, 32'h8000_5000);
    @(negedge clk);
    chk("lock24_state", 32'(st), 32'h3);
    word(1'b1, 32'h8000_5004);
    @(negedge clk);
    chk("s24_push", 32'(rx_if.fifo_push), 32'h1);
    chk("s24_data", rx_if.fifo_data, 32'h8000_5004);
    idle(15);

    rst = 1'b1;
    word(1'b1, 32'h8000_5005);
    @(negedge clk);
    chk("mrst_push",   32'(rx_if.fifo_push), 32'h0);
    chk("mrst_state",  32'(st), 32'h0);
    chk("mrst_locked", 32'(locked), 32'h0);
    chk("mrst_lost",   32'(lost), 32'h0);
    chk("mrst_drop",   32'(drop), 32'h0);
    rst = 1'b0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
